// File: rtl/key_pkg.sv
// Shared constants and helpers for the panel-button conditioning front end.
package key_pkg;

   localparam int KEY_W = 8;
   localparam int CONFLICT_IDX = 8;
   localparam logic [KEY_W-1:0] RELEASED = 8'hFF;

   localparam int DEF_TICK_DIV = 24000;
   localparam int DEF_STABLE_TICKS = 10;

   // Number of buttons at the pressed (low) level.
   function automatic logic [3:0] count_pressed(input logic [KEY_W-1:0] lvl);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < KEY_W; i++) begin
         n = n + {3'd0, ~lvl[i]};
      end
      return n;
   endfunction

   function automatic logic [2:0] lowest_index(input logic [KEY_W-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = KEY_W - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button pins in, debounced KEY bus and press event out.
interface key_debounce_if;
   import key_pkg::*;

   logic [KEY_W-1:0] BTN_N;
   logic [KEY_W:0]   KEY;
   logic             PRESS_STB;
   logic [2:0]       PRESS_CODE;

   modport master (output BTN_N, input KEY, input PRESS_STB, input PRESS_CODE);
   modport slave  (input BTN_N, output KEY, output PRESS_STB, output PRESS_CODE);
endinterface

// File: rtl/key_debounce_bit.sv
// One button: two-flop synchroniser plus tick-based stability counter.
module key_debounce_bit
   import key_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic CLK,
   input  logic RESET,
   input  logic tick,
   input  logic raw,
   output logic deb,
   output logic deb_nxt
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

   logic       sync1_q, sync2_q;
   logic       deb_q, deb_d;
   logic [7:0] stab_cnt_q, stab_cnt_d;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         deb_q      <= 1'b1;
         stab_cnt_q <= 8'd0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         stab_cnt_q <= stab_cnt_d;
      end
   end

   // Any cycle where the input agrees with the accepted level restarts the count,
   // so glitches between ticks are discarded too.
   always_comb begin
      deb_d      = deb_q;
      stab_cnt_d = stab_cnt_q;
      if (sync2_q == deb_q) begin
         stab_cnt_d = 8'd0;
      end else if (tick) begin
         if (stab_cnt_q == CNT_LAST) begin
            deb_d      = sync2_q;
            stab_cnt_d = 8'd0;
         end else begin
            stab_cnt_d = stab_cnt_q + 8'd1;
         end
      end
   end

   assign deb     = deb_q;
   assign deb_nxt = deb_d;

endmodule

// File: rtl/key_debounce.sv
// Panel button front end: shared sample tick, eight debouncers, conflict flag
// and press-event encoder.
module key_debounce
   import key_pkg::*;
#(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic           CLK,
   input  logic           RESET,
   key_debounce_if.slave  bus
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick;

   logic [KEY_W-1:0] deb, deb_nxt, fell;

   logic             conflict_q, conflict_d;
   logic             press_stb_q, press_stb_d;
   logic [2:0]       press_code_q, press_code_d;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tick_cnt_q   <= '0;
         conflict_q   <= 1'b0;
         press_stb_q  <= 1'b0;
         press_code_q <= 3'd0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         conflict_q   <= conflict_d;
         press_stb_q  <= press_stb_d;
         press_code_q <= press_code_d;
      end
   end

   // Free-running divider; never realigned to input edges.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   for (genvar i = 0; i < KEY_W; i++) begin : g_bit
      key_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .CLK     (CLK),
         .RESET   (RESET),
         .tick    (tick),
         .raw     (bus.BTN_N[i]),
         .deb     (deb[i]),
         .deb_nxt (deb_nxt[i])
      );
   end

   // Flag and event logic look at next-state levels so they land with KEY[7:0].
   always_comb begin
      fell         = deb & ~deb_nxt;
      conflict_d   = (count_pressed(deb_nxt) >= 4'd2);
      press_stb_d  = |fell;
      press_code_d = press_code_q;
      if (|fell) press_code_d = lowest_index(fell);
   end

   assign bus.KEY[KEY_W-1:0]   = deb;
   assign bus.KEY[CONFLICT_IDX] = conflict_q;
   assign bus.PRESS_STB        = press_stb_q;
   assign bus.PRESS_CODE       = press_code_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_key_debounce;
   import key_pkg::*;

   localparam int TD = 4;
   localparam int ST = 3;
   localparam int LAT_LO = (ST - 1) * TD + 3;
   localparam int LAT_HI = ST * TD + 2;

   typedef struct {
      logic [2:0] code;
      logic [8:0] key;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   key_debounce_if bus ();

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   key_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Every strobe must match the oldest expected press.
   always @(negedge CLK) begin
      if (!RESET && bus.PRESS_STB === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_stb", 32'(bus.KEY), 32'h1FF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stb_code", 32'(bus.PRESS_CODE), 32'(e.code));
            chk("stb_key", 32'(bus.KEY), 32'(e.key));
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(posedge CLK);
      #1;
   endtask

   task automatic wait_key(input string tag, input int budget, output int n);
      logic [8:0] prev;
      prev = bus.KEY;
      n = 0;
      while (n < budget) begin
         @(posedge CLK);
         n++;
         #1;
         if (bus.KEY !== prev) break;
      end
      if (bus.KEY === prev) chk({tag, "_timeout"}, 32'(n), 32'(budget + 1));
   endtask

   task automatic drive(input logic [7:0] v);
      bus.BTN_N = v;
   endtask

   initial begin
      int  n;
      bit  held;

      RESET = 1'b1;
      bus.BTN_N = 8'hFF;
      #2;
      chk("rst_key", 32'(bus.KEY), 32'h0FF);
      chk("rst_stb", 32'(bus.PRESS_STB), 32'h0);
      chk("rst_code", 32'(bus.PRESS_CODE), 32'h0);
      step(3);
      RESET = 1'b0;
      step(5);

      // Reset mid-debounce with all buttons low
      drive(8'h00);
      step(6);
      #3;
      RESET = 1'b1;
      #1;
      chk("midrst_key", 32'(bus.KEY), 32'h0FF);
      chk("midrst_stb", 32'(bus.PRESS_STB), 32'h0);
      step(3);
      RESET = 1'b0;
      sb_q.push_back('{code: 3'd0, key: 9'h100});
      wait_key("rstexit", 40, n);
      chk("rstexit_key", 32'(bus.KEY), 32'h100);
      step(3);
      chk("rstexit_sb_empty", 32'(sb_q.size()), 32'h0);
      drive(8'hFF);
      wait_key("rstexit_rel", 40, n);
      chk("rstexit_rel_key", 32'(bus.KEY), 32'h0FF);
      step(5);

      // Clean press on bit 5
      drive(8'hDF);
      sb_q.push_back('{code: 3'd5, key: 9'h0DF});
      wait_key("press5", 40, n);
      chk("press5_key", 32'(bus.KEY), 32'h0DF);
      chk("press5_lat_in_range", 32'(n >= LAT_LO && n <= LAT_HI), 32'h1);
      step(3);
      chk("press5_sb_empty", 32'(sb_q.size()), 32'h0);
      drive(8'hFF);
      wait_key("rel5", 40, n);
      chk("rel5_key", 32'(bus.KEY), 32'h0FF);
      chk("rel5_lat_in_range", 32'(n >= LAT_LO && n <= LAT_HI), 32'h1);
      step(5);

      // Bounce on bit 2: toggle every 5 cycles for 40 cycles, then hold low
      held = 1'b1;
      for (int t = 0; t < 8; t++) begin
         bus.BTN_N[2] = ~bus.BTN_N[2];
         for (int c = 0; c < 5; c++) begin
            @(posedge CLK);
            #1;
            if (bus.KEY !== 9'h0FF) held = 1'b0;
         end
      end
      chk("bounce_key_held", 32'(held), 32'h1);
      drive(8'hFB);
      sb_q.push_back('{code: 3'd2, key: 9'h0FB});
      wait_key("bounce", 40, n);
      chk("bounce_key", 32'(bus.KEY), 32'h0FB);
      chk("bounce_lat_max", 32'(n <= LAT_HI), 32'h1);
      step(3);
      chk("bounce_sb_empty", 32'(sb_q.size()), 32'h0);
      drive(8'hFF);
      wait_key("bounce_rel", 40, n);
      step(5);

      // One-cycle glitch on bit 0
      drive(8'hFE);
      step(1);
      drive(8'hFF);
      step(25);
      chk("glitch_key", 32'(bus.KEY), 32'h0FF);

      // Simultaneous press of bits 3 and 4
      drive(8'hE7);
      sb_q.push_back('{code: 3'd3, key: 9'h1E7});
      wait_key("simul", 40, n);
      chk("simul_key", 32'(bus.KEY), 32'h1E7);
      step(3);
      chk("simul_sb_empty", 32'(sb_q.size()), 32'h0);
      drive(8'hF7);
      wait_key("simul_rel4", 40, n);
      chk("simul_rel4_key", 32'(bus.KEY), 32'h0F7);
      chk("code_held", 32'(bus.PRESS_CODE), 32'h3);
      drive(8'hFF);
      wait_key("simul_rel", 40, n);
      chk("simul_rel_key", 32'(bus.KEY), 32'h0FF);
      step(5);

      // Sequential press: bit 1 held, then bit 6
      drive(8'hFD);
      sb_q.push_back('{code: 3'd1, key: 9'h0FD});
      wait_key("seq1", 40, n);
      chk("seq1_key", 32'(bus.KEY), 32'h0FD);
      step(4);
      drive(8'hBD);
      sb_q.push_back('{code: 3'd6, key: 9'h1BD});
      wait_key("seq6", 40, n);
      chk("seq6_key", 32'(bus.KEY), 32'h1BD);
      chk("seq6_stb_same_cycle", 32'(bus.PRESS_STB), 32'h1);
      step(3);
      chk("seq_sb_empty", 32'(sb_q.size()), 32'h0);
      drive(8'hFF);
      wait_key("seq_rel", 40, n);
      chk("seq_rel_key", 32'(bus.KEY), 32'h0FF);
      step(10);

      chk("final_sb_empty", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
